// File: rtl/vote_round_tally.sv
// vote_round_tally: per-session tally of one-hot 3-voter counts and final majority.
// Optional per-vote-count histogram (hist_flat) enabled by defining TALLY_HIST_EN.
module vote_round_tally #(
    parameter  int NUM_ROUNDS = 5,
    localparam int RND_W      = $clog2(NUM_ROUNDS + 1),
    localparam int VOTE_W     = $clog2(3 * NUM_ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        count_onehot,
    input  logic              count_valid,
    output logic              count_ready,
    output logic [RND_W-1:0]  approved_cnt,
    output logic [RND_W-1:0]  rejected_cnt,
    output logic [RND_W-1:0]  rounds_done,
    output logic [VOTE_W-1:0] total_votes,
    output logic              done,
    output logic              final_approved,
    output logic              err_onehot
`ifdef TALLY_HIST_EN
    ,
    output logic [4*RND_W-1:0] hist_flat
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

    logic [1:0]       state;
    logic             word_ok;
    logic [1:0]       k;
    logic             xfer;
    logic             take;
    logic             clr;
    logic             is_appr;
    logic [RND_W-1:0] rounds_nx;
    logic [RND_W-1:0] appr_nx;
    logic [RND_W-1:0] rej_nx;
    logic             last_rnd;

    // Decode the one-hot count word into a vote count k and a validity flag.
    always_comb begin
        word_ok = 1'b1;
        k       = 2'd0;
        case (count_onehot)
            4'b0001: k = 2'd0;
            4'b0010: k = 2'd1;
            4'b0100: k = 2'd2;
            4'b1000: k = 2'd3;
            default: word_ok = 1'b0;
        endcase
    end

    // Handshake qualifiers and post-update counts for the final decision.
    always_comb begin
        xfer      = count_valid && count_ready;
        take      = xfer && word_ok;
        clr       = start && (state != COLLECT);
        is_appr   = k[1];
        rounds_nx = rounds_done + RND_W'(1);
        appr_nx   = approved_cnt + RND_W'(is_appr);
        rej_nx    = rejected_cnt + RND_W'(!is_appr);
        last_rnd  = (rounds_nx == LAST_RND);
    end

    // Session FSM; ready, done and the final decision are registered with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            count_ready    <= 1'b0;
            done           <= 1'b0;
            final_approved <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= COLLECT;
                        count_ready <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (take && last_rnd) begin
                        state          <= DONE;
                        count_ready    <= 1'b0;
                        done           <= 1'b1;
                        final_approved <= (appr_nx > rej_nx);
                    end
                end
                DONE: begin
                    if (start) begin
                        state          <= COLLECT;
                        count_ready    <= 1'b1;
                        done           <= 1'b0;
                        final_approved <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    count_ready    <= 1'b0;
                    done           <= 1'b0;
                    final_approved <= 1'b0;
                end
            endcase
        end
    end

    // Round counters and sticky error; bad words are consumed but not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            approved_cnt <= '0;
            rejected_cnt <= '0;
            rounds_done  <= '0;
            total_votes  <= '0;
            err_onehot   <= 1'b0;
        end else if (clr) begin
            approved_cnt <= '0;
            rejected_cnt <= '0;
            rounds_done  <= '0;
            total_votes  <= '0;
            err_onehot   <= 1'b0;
        end else if (xfer) begin
            if (!word_ok) begin
                err_onehot <= 1'b1;
            end else begin
                rounds_done  <= rounds_nx;
                total_votes  <= total_votes + VOTE_W'(k);
                approved_cnt <= appr_nx;
                rejected_cnt <= rej_nx;
            end
        end
    end

`ifdef TALLY_HIST_EN
    logic [RND_W-1:0] hist [4];

    // One counter per vote count; only valid rounds are binned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (take) begin
            hist[k] <= hist[k] + RND_W'(1);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_hist
        assign hist_flat[g*RND_W +: RND_W] = hist[g];
    end
`endif

endmodule
